// File: rtl/general_defs_pkg.sv
// Shared definitions for the pipeline datapath: word/address widths,
// stall-counter width and the buffer operation encoding.
package general_defs;

    localparam int unsigned WORD             = 32;
    localparam int unsigned ADDR_WIDTH       = 5;
    localparam int unsigned PIPE_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        BUF_IDLE     = 2'b00,
        BUF_POP      = 2'b01,
        BUF_PUSH     = 2'b10,
        BUF_PUSH_POP = 2'b11
    } buf_op_e;

endpackage

// File: rtl/pipe_ptr_counter.sv
// Wrapping pointer with enable and synchronous clear; wraps at 2**PTR_W,
// which equals the buffer depth because depth is a power of two.
module pipe_ptr_counter #(
    parameter int unsigned PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_o <= '0;
        end else if (clr_i) begin
            ptr_o <= '0;
        end else if (en_i) begin
            ptr_o <= ptr_o + PTR_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Data-agnostic valid/ready pipeline buffer: flop-array FIFO with flush
// and a saturating backpressure-cycle counter.
module pipe_stage_buffer
    import general_defs::*;
#(
    parameter int unsigned DATA_W = WORD,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          flush_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [DATA_W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [PIPE_STALL_CNT_W-1:0]   stall_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;
    buf_op_e           op;

    // Handshakes decode from registered count only; flush masks both.
    assign ready_o = (count_o < CNT_W'(DEPTH));
    assign valid_o = (count_o != '0);
    assign data_o  = mem[head];
    assign push    = valid_i && ready_o && !flush_i;
    assign pop     = valid_o && ready_i && !flush_i;

    always_comb begin
        op = BUF_IDLE;
        unique case ({push, pop})
            2'b10:   op = BUF_PUSH;
            2'b01:   op = BUF_POP;
            2'b11:   op = BUF_PUSH_POP;
            default: op = BUF_IDLE;
        endcase
    end

    pipe_ptr_counter #(.PTR_W(PTR_W)) u_head_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (pop),
        .clr_i   (flush_i),
        .ptr_o   (head)
    );

    pipe_ptr_counter #(.PTR_W(PTR_W)) u_tail_ptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (push),
        .clr_i   (flush_i),
        .ptr_o   (tail)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (flush_i) begin
            count_o <= '0;
        end else begin
            unique case (op)
                BUF_PUSH: count_o <= count_o + CNT_W'(1);
                BUF_POP:  count_o <= count_o - CNT_W'(1);
                default:  count_o <= count_o;
            endcase
        end
    end

    // Storage resets so data_o reads zero while reset is held.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[tail] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && !flush_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + PIPE_STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_buffer.md
PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default WORD (32): payload width in bits, legal range 1..256.
REQ-002 Parameter DEPTH, default 2: number of storage entries, legal range 2..8, power of two.
REQ-003 clk_i  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 valid_i  input  1  upstream payload valid.
REQ-006 ready_o  output  1  buffer can accept a payload this cycle.
REQ-007 data_i  input  DATA_W  upstream payload.
REQ-008 flush_i  input  1  synchronous discard of all held entries.
REQ-009 valid_o  output  1  head entry is valid.
REQ-010 ready_i  input  1  downstream accepts the head this cycle.
REQ-011 data_o  output  DATA_W  head payload.
REQ-012 count_o  output  $clog2(DEPTH)+1  number of held entries.
REQ-013 stall_cnt_o  output  PIPE_STALL_CNT_W  saturating count of backpressure cycles.

Function
REQ-014 Push SHALL occur when valid_i && ready_o is true at a rising edge; pop SHALL occur when valid_o && ready_i is true at a rising edge.
REQ-015 ready_o SHALL equal (count_o < DEPTH), decoded from registered count only, with no combinational path from ready_i.
REQ-016 valid_o SHALL equal (count_o != 0); data_o SHALL be the oldest held entry, with no combinational path from data_i.
REQ-017 Latency: a payload pushed at edge N SHALL appear on data_o after edge N when the buffer was empty.
REQ-018 Ordering SHALL be strict FIFO; no payload is dropped or duplicated except by flush.
REQ-019 While valid_o && !ready_i, data_o and valid_o SHALL hold stable until the pop.
REQ-020 Simultaneous push and pop SHALL leave count_o unchanged, write the tail and advance the head in the same edge.
REQ-021 When full, ready_o = 0 and valid_i SHALL be ignored, including when ready_i = 1 in that cycle (no pass-through when full).
REQ-022 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-023 flush_i = 1 at an edge SHALL set count_o to 0 and reset both pointers to 0, overriding any push or pop in that cycle.
REQ-024 In a flush cycle, data_i is dropped and ready_o may still read 1.
REQ-025 stall_cnt_o SHALL increment on every edge where valid_o && !ready_i && !flush_i, and saturate at all-ones.
REQ-026 stall_cnt_o SHALL be cleared only by reset.

Reset
REQ-027 While reset_i is high, the following outputs SHALL be forced low immediately, without waiting for a clock edge: valid_o, count_o, stall_cnt_o, both pointers.
REQ-028 While reset_i is high, ready_o SHALL read 1 and all storage entries, including data_o, SHALL read 0.
REQ-029 After reset is deasserted, the first push SHALL be accepted on the first rising edge.

Structure
REQ-030 PIPE_STALL_CNT_W (16) SHALL be added to the shared GENERAL_DEFS package alongside WORD and ADDR_WIDTH.
REQ-031 pipe_stage_buffer SHALL be data-agnostic; stage payloads (valid, write enables, dest addr, ALU result, store data) are packed into data_i by the instantiating stage.
REQ-032 One sub-module, pipe_ptr_counter, SHALL implement a wrapping pointer with enable and synchronous clear, instantiated for head and tail.
REQ-033 The storage array SHALL be a flop array of DEPTH x DATA_W, not inferred RAM.

Verification
REQ-034 Reset mid-stream: DEPTH=2 holding 2 entries, pulse reset_i between edges -> valid_o, count_o and stall_cnt_o are 0 before the next edge, and ready_o=1.
REQ-035 Fill and backpressure: DEPTH=4, push 0xA1..0xA4 with ready_i=0 -> count_o=4, ready_o=0; a push of 0xA5 is ignored; stall_cnt_o increments every cycle; data_o=0xA1 throughout.
REQ-036 Drain with wrap: continue from REQ-035 with ready_i=1 and push 0xB1..0xB6 each cycle -> output order is A1,A2,A3,A4,B1..B6 and pointers wrap without loss.
REQ-037 Simultaneous push/pop: count_o=1 (0x10) with push of 0x11 and ready_i=1 -> count_o stays 1 and data_o=0x11 on the next cycle.
REQ-038 Flush priority: count_o=3 with flush_i=1, valid_i=1 and data 0x55 -> count_o=0, valid_o=0 next cycle, and 0x55 never appears.
REQ-039 Counter saturation: hold valid_o=1 and ready_i=0 for 65540 cycles -> stall_cnt_o=0xFFFF.
